// File: rtl/vram_req_bridge.sv
// vram_req_bridge
// Memory-side responder for the game logic's VRAM request interface.
// Client writes and reads share one in-order command FIFO. Commands are
// issued one at a time on a req/ack memory port. Read results return
// through a show-ahead read-data FIFO. A read is issued only when its
// result is guaranteed a slot, so a blocked read stalls every later
// command behind it.

module vram_req_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CDEPTH = 4,
    parameter int RDEPTH = 4
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read,
    input  logic [ADDR_W-1:0] readaddr,
    output logic              wr_full,
    output logic              rd_empty,
    output logic [DATA_W-1:0] readdata,
    input  logic              rd_pop,
    output logic              cmd_drop,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CAW   = $clog2(CDEPTH);
    localparam int RAW   = $clog2(RDEPTH);
    localparam int CMD_W = 1 + ADDR_W + DATA_W;

    localparam logic [CAW:0] CPTR_ONE = {{CAW{1'b0}}, 1'b1};
    localparam logic [RAW:0] RPTR_ONE = {{RAW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Command FIFO: entry = {we, addr, wdata}
    logic [CMD_W-1:0]  cmd_mem_r [CDEPTH];
    logic [CAW:0]      cmd_wptr_r;
    logic [CAW:0]      cmd_rptr_r;
    logic              cmd_full_s;
    logic              cmd_empty_s;
    logic              cmd_push_s;
    logic              cmd_pop_s;
    logic [CMD_W-1:0]  cmd_wentry_s;
    logic [CMD_W-1:0]  cmd_head_s;
    logic              head_we_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;
    logic              drop_s;
    logic              cmd_drop_r;

    // Read-data FIFO
    logic [DATA_W-1:0] rd_mem_r [RDEPTH];
    logic [RAW:0]      rd_wptr_r;
    logic [RAW:0]      rd_rptr_r;
    logic              rd_full_s;
    logic              rd_empty_s;
    logic              rd_push_s;
    logic              rd_pop_s;

    // Memory port state
    state_t            state_r;
    state_t            next_state_s;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_req_nxt_s;
    logic              mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_nxt_s;

    // Pointer-derived FIFO status; MSB differs only when the writer has lapped the reader
    assign cmd_empty_s = (cmd_wptr_r == cmd_rptr_r);
    assign cmd_full_s  = (cmd_wptr_r[CAW] != cmd_rptr_r[CAW]) &&
                         (cmd_wptr_r[CAW-1:0] == cmd_rptr_r[CAW-1:0]);
    assign rd_empty_s  = (rd_wptr_r == rd_rptr_r);
    assign rd_full_s   = (rd_wptr_r[RAW] != rd_rptr_r[RAW]) &&
                         (rd_wptr_r[RAW-1:0] == rd_rptr_r[RAW-1:0]);

    assign cmd_head_s  = cmd_mem_r[cmd_rptr_r[CAW-1:0]];
    assign head_we_s   = cmd_head_s[CMD_W-1];
    assign head_addr_s = cmd_head_s[CMD_W-2 -: ADDR_W];
    assign head_data_s = cmd_head_s[DATA_W-1:0];

    assign rd_pop_s    = rd_pop && !rd_empty_s;

    assign wr_full     = cmd_full_s;
    assign rd_empty    = rd_empty_s;
    assign readdata    = rd_empty_s ? {DATA_W{1'b0}} : rd_mem_r[rd_rptr_r[RAW-1:0]];
    assign cmd_drop    = cmd_drop_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;

    // Client request arbitration: write wins over read, anything arriving while full is dropped
    always_comb begin
        cmd_wentry_s = {CMD_W{1'b0}};
        cmd_push_s   = 1'b0;
        drop_s       = 1'b0;
        if (write) begin
            cmd_wentry_s = {1'b1, writeaddr, writedata};
        end else if (read) begin
            cmd_wentry_s = {1'b0, readaddr, {DATA_W{1'b0}}};
        end else begin
            cmd_wentry_s = {CMD_W{1'b0}};
        end
        if ((write || read) && !cmd_full_s) begin
            cmd_push_s = 1'b1;
        end else begin
            cmd_push_s = 1'b0;
        end
        if ((write && read) || ((write || read) && cmd_full_s)) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Command FIFO storage write
    always_ff @(posedge clk) begin
        if (cmd_push_s) begin
            cmd_mem_r[cmd_wptr_r[CAW-1:0]] <= cmd_wentry_s;
        end
    end

    // Command FIFO pointers and drop pulse
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cmd_wptr_r <= {(CAW+1){1'b0}};
            cmd_rptr_r <= {(CAW+1){1'b0}};
            cmd_drop_r <= 1'b0;
        end else begin
            if (cmd_push_s) begin
                cmd_wptr_r <= cmd_wptr_r + CPTR_ONE;
            end
            if (cmd_pop_s) begin
                cmd_rptr_r <= cmd_rptr_r + CPTR_ONE;
            end
            cmd_drop_r <= drop_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state: a read only leaves IDLE once its result has a guaranteed slot
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!cmd_empty_s && (head_we_s || !rd_full_s)) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: next memory-port values plus FIFO pop/push strobes on completion
    always_comb begin
        mem_req_nxt_s   = mem_req_r;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        cmd_pop_s       = 1'b0;
        rd_push_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (next_state_s == ST_ISSUE) begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = head_we_s;
                    mem_addr_nxt_s  = head_addr_s;
                    mem_wdata_nxt_s = head_data_s;
                end else begin
                    mem_req_nxt_s   = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    mem_req_nxt_s = 1'b0;
                    cmd_pop_s     = 1'b1;
                    rd_push_s     = !mem_we_r && (!rd_full_s || rd_pop_s);
                end else begin
                    mem_req_nxt_s = 1'b1;
                end
            end
            default: begin
                mem_req_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered memory-port outputs, held stable for the whole request
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
        end
    end

    // Read-data FIFO storage write
    always_ff @(posedge clk) begin
        if (rd_push_s) begin
            rd_mem_r[rd_wptr_r[RAW-1:0]] <= mem_rdata;
        end
    end

    // Read-data FIFO pointers
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_wptr_r <= {(RAW+1){1'b0}};
            rd_rptr_r <= {(RAW+1){1'b0}};
        end else begin
            if (rd_push_s) begin
                rd_wptr_r <= rd_wptr_r + RPTR_ONE;
            end
            if (rd_pop_s) begin
                rd_rptr_r <= rd_rptr_r + RPTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_vram_req_bridge.sv
// Testbench for vram_req_bridge: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.

module tb_vram_req_bridge;

    localparam int CDEPTH = 4;
    localparam int RDEPTH = 4;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } cmd_t;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        write = 1'b0;
    logic [15:0] writeaddr = 16'h0000;
    logic [15:0] writedata = 16'h0000;
    logic        read = 1'b0;
    logic [15:0] readaddr = 16'h0000;
    logic        rd_pop = 1'b0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        wr_full;
    logic        rd_empty;
    logic [15:0] readdata;
    logic        cmd_drop;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    cmd_t        cmdq[$];
    logic [15:0] rdq[$];
    cmd_t        txlog[$];
    logic [15:0] mem_model [logic [15:0]];
    logic        m_req, m_we, m_drop;
    logic [15:0] m_addr, m_wdata;

    vram_req_bridge #(
        .ADDR_W(16), .DATA_W(16), .CDEPTH(CDEPTH), .RDEPTH(RDEPTH)
    ) dut (
        .clk(clk), .Reset_n(Reset_n),
        .write(write), .writeaddr(writeaddr), .writedata(writedata),
        .read(read), .readaddr(readaddr),
        .wr_full(wr_full), .rd_empty(rd_empty), .readdata(readdata),
        .rd_pop(rd_pop), .cmd_drop(cmd_drop),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cmdq.delete();
        rdq.delete();
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = 16'h0000;
        m_wdata = 16'h0000;
        m_drop  = 1'b0;
    endtask

    function automatic logic [15:0] lookup(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 16'($urandom);
    endfunction

    // Advance one clock: update model from pre-edge inputs, then compare DUT
    task automatic tick();
        bit          req_in, pre_full, rdpop_ok;
        int          pre_rd;
        cmd_t        ent, done;
        logic [15:0] junk;
        if (Reset_n) begin
            req_in   = write || read;
            pre_full = (cmdq.size() == CDEPTH);
            pre_rd   = rdq.size();
            rdpop_ok = rd_pop && (pre_rd > 0);
            m_drop   = (write && read) || (req_in && pre_full);
            ent.we   = write;
            ent.addr = write ? writeaddr : readaddr;
            ent.data = write ? writedata : 16'h0000;
            if (m_req) begin
                if (mem_ack) begin
                    done = cmdq.pop_front();
                    txlog.push_back(done);
                    if (done.we) mem_model[done.addr] = done.data;
                    else rdq.push_back(mem_rdata);
                    m_req = 1'b0;
                end
            end else if (cmdq.size() > 0 && (cmdq[0].we || pre_rd < RDEPTH)) begin
                m_req   = 1'b1;
                m_we    = cmdq[0].we;
                m_addr  = cmdq[0].addr;
                m_wdata = cmdq[0].data;
            end
            if (rdpop_ok) junk = rdq.pop_front();
            if (req_in && !pre_full) cmdq.push_back(ent);
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
        check("mem_req", mem_req, m_req);
        if (m_req) begin
            check("mem_we", mem_we, m_we);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        check("wr_full", wr_full, cmdq.size() == CDEPTH);
        check("rd_empty", rd_empty, rdq.size() == 0);
        check("readdata", readdata, (rdq.size() > 0) ? rdq[0] : 16'h0000);
        check("cmd_drop", cmd_drop, m_drop);
    endtask

    // Memory responder: ack a request as soon as the model expects one
    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack   = m_req;
            mem_rdata = (m_req && !m_we) ? lookup(m_addr) : 16'h0000;
            tick();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 Reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_wr_full", wr_full, 1'b0);
        check("rst_rd_empty", rd_empty, 1'b1);
        check("rst_readdata", readdata, 16'h0000);
        check("rst_cmd_drop", cmd_drop, 1'b0);
        Reset_n = 1'b1;

        // Single write, ack after three cycles
        write = 1'b1; writeaddr = 16'h0001; writedata = 16'h0001;
        tick();
        write = 1'b0;
        tick();
        check("t1_req", mem_req, 1'b1);
        check("t1_we", mem_we, 1'b1);
        check("t1_addr", mem_addr, 16'h0001);
        check("t1_wdata", mem_wdata, 16'h0001);
        tick(); tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t1_req_low", mem_req, 1'b0);
        check("t1_wr_full", wr_full, 1'b0);

        // Write then read back the same address
        write = 1'b1; writeaddr = 16'h0003; writedata = 16'h0003;
        tick();
        write = 1'b0; read = 1'b1; readaddr = 16'h0003;
        tick();
        read = 1'b0;
        serve(6);
        check("t2_rd_empty", rd_empty, 1'b0);
        check("t2_readdata", readdata, 16'h0003);
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        check("t2_pop_empty", rd_empty, 1'b1);
        check("t2_pop_data", readdata, 16'h0000);

        // Five pushes with memory stalled: fifth dropped
        txlog.delete();
        for (int i = 0; i < 5; i++) begin
            write = 1'b1; writeaddr = 16'h0010 + 16'(i); writedata = 16'h00A0 + 16'(i);
            tick();
            if (i == 3) check("t3_full", wr_full, 1'b1);
            if (i == 4) check("t3_drop", cmd_drop, 1'b1);
        end
        write = 1'b0;
        tick();
        check("t3_drop_end", cmd_drop, 1'b0);
        serve(12);
        check("t3_tx_count", txlog.size(), 4);
        for (int i = 0; i < txlog.size(); i++) begin
            check("t3_tx_addr", txlog[i].addr, 16'h0010 + 16'(i));
        end

        // Simultaneous write and read: write wins
        txlog.delete();
        write = 1'b1; writeaddr = 16'h0020; writedata = 16'h5555;
        read = 1'b1; readaddr = 16'h0021;
        tick();
        write = 1'b0; read = 1'b0;
        check("t4_drop", cmd_drop, 1'b1);
        tick();
        check("t4_drop_end", cmd_drop, 1'b0);
        serve(6);
        check("t4_tx_count", txlog.size(), 1);
        if (txlog.size() > 0) begin
            check("t4_tx_we", txlog[0].we, 1'b1);
            check("t4_tx_addr", txlog[0].addr, 16'h0020);
        end

        // Head-of-line blocking behind a full read-data FIFO
        txlog.delete();
        for (int i = 0; i < 4; i++) begin
            read = 1'b1; readaddr = 16'h0010 + 16'(i);
            serve(1);
        end
        read = 1'b0;
        serve(10);
        check("t5_head", readdata, 16'h00A0);
        read = 1'b1; readaddr = 16'h0014;
        serve(1);
        read = 1'b0; write = 1'b1; writeaddr = 16'h0030; writedata = 16'h7777;
        serve(1);
        write = 1'b0;
        serve(10);
        check("t5_blocked_cnt", txlog.size(), 4);
        check("t5_blocked_req", mem_req, 1'b0);
        rd_pop = 1'b1;
        serve(1);
        rd_pop = 1'b0;
        serve(10);
        check("t5_tx_count", txlog.size(), 6);
        if (txlog.size() == 6) begin
            check("t5_rd_we", txlog[4].we, 1'b0);
            check("t5_rd_addr", txlog[4].addr, 16'h0014);
            check("t5_wr_we", txlog[5].we, 1'b1);
            check("t5_wr_addr", txlog[5].addr, 16'h0030);
        end
        rd_pop = 1'b1;
        serve(8);
        rd_pop = 1'b0;
        check("t5_drained", rd_empty, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            write     = ($urandom_range(0, 3) == 0);
            read      = ($urandom_range(0, 2) == 0);
            writeaddr = 16'($urandom_range(0, 15));
            writedata = 16'($urandom);
            readaddr  = 16'($urandom_range(0, 15));
            rd_pop    = ($urandom_range(0, 2) == 0);
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = 16'($urandom);
            tick();
        end
        write = 1'b0; read = 1'b0; mem_ack = 1'b0;
        rd_pop = 1'b1;
        serve(30);
        rd_pop = 1'b0;
        serve(2);

        // Reset in the middle of a request
        write = 1'b1; writeaddr = 16'h0040; writedata = 16'h1234;
        tick();
        write = 1'b0;
        tick();
        check("t6_req_before", mem_req, 1'b1);
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("t6_mem_req", mem_req, 1'b0);
        check("t6_mem_we", mem_we, 1'b0);
        check("t6_mem_addr", mem_addr, 16'h0000);
        check("t6_mem_wdata", mem_wdata, 16'h0000);
        check("t6_wr_full", wr_full, 1'b0);
        check("t6_rd_empty", rd_empty, 1'b1);
        check("t6_readdata", readdata, 16'h0000);
        check("t6_cmd_drop", cmd_drop, 1'b0);
        tick();
        Reset_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("t6_late_ack_empty", rd_empty, 1'b1);
        check("t6_late_ack_req", mem_req, 1'b0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
